rst_release_sequencer: RTL and testbench

- Reset controller for the SoC's asynchronously reset register domains.
- Asserts all domain resets immediately and asynchronously on rst.
- Synchronises rst deassertion to clk, then releases N_DOM domain resets one at a time in fixed order, with programmed hold and gap times.
- Also serves a software reset request/acknowledge handshake that re-runs the same sequence without a global rst.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_sync_chain.sv | 23 ++
 rtl/rst_release_sequencer.sv | 130 +++++++++++++
 tb/tb_rst_release_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
// Optional event counter is enabled by defining RST_SEQ_EVENT_CNT_EN.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2,
        RUN  = 2'd3
    } rst_state_e;

    localparam int EVT_CNT_W = 8;

    // Width of a counter that must reach max(a, b) - 1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert, clocked-release synchroniser for the global reset.
// All stages are forced high by rst; zeros shift in once rst drops.
module rst_sync_chain #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_s = chain[STAGES-1];

endmodule

// File: rtl/rst_release_sequencer.sv
// Releases N_DOM domain resets in order after rst or a software request.
// Defining RST_SEQ_EVENT_CNT_EN adds the saturating sw_rst_cnt output.
module rst_release_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_DOM       = 4,
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_req,
    output logic                 sw_ack,
    output logic                 busy,
`ifdef RST_SEQ_EVENT_CNT_EN
    output logic [EVT_CNT_W-1:0] sw_rst_cnt,
`endif
    output logic [N_DOM-1:0]     dom_rst
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    logic             rst_s;
    rst_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             sw_pend;
    logic             armed;
    logic             sw_start;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    assign sw_start = (state == RUN) && sw_req && armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SYNC;
            cnt     <= '0;
            idx     <= '0;
            dom_rst <= '1;
            busy    <= 1'b1;
            sw_ack  <= 1'b0;
            sw_pend <= 1'b0;
            armed   <= 1'b1;
        end else begin
            sw_ack <= 1'b0;
            busy   <= |dom_rst;
            // Re-arming needs sw_req seen low, so a held request cannot retrigger.
            if (!sw_req) begin
                armed <= 1'b1;
            end
            case (state)
                SYNC: begin
                    if (!rst_s) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        dom_rst[0] <= 1'b0;
                        idx        <= IDX_W'(1);
                        cnt        <= '0;
                        if (N_DOM == 1) begin
                            state   <= RUN;
                            sw_ack  <= sw_pend;
                            sw_pend <= 1'b0;
                        end else begin
                            state <= REL;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL: begin
                    if (cnt == GAP_LAST) begin
                        dom_rst[idx] <= 1'b0;
                        cnt          <= '0;
                        if (idx == IDX_LAST) begin
                            state   <= RUN;
                            sw_ack  <= sw_pend;
                            sw_pend <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (sw_start) begin
                        dom_rst <= '1;
                        busy    <= 1'b1;
                        sw_pend <= 1'b1;
                        armed   <= 1'b0;
                        cnt     <= '0;
                        idx     <= '0;
                        state   <= HOLD;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

`ifdef RST_SEQ_EVENT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rst_cnt <= '0;
        end else if (sw_start && (sw_rst_cnt != '1)) begin
            sw_rst_cnt <= sw_rst_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed bench for rst_release_sequencer with a per-cycle expected queue.
// Build with RST_SEQ_EVENT_CNT_EN to also cover the software reset counter.
module tb_rst_release_sequencer;

    localparam int N_DOM       = 4;
    localparam int SYNC_STAGES = 3;
    localparam int HOLD_CYCLES = 16;
    localparam int GAP_CYCLES  = 4;
    localparam int W           = N_DOM + 2;
    localparam int POR_BASE    = SYNC_STAGES + 1;

    logic             clk;
    logic             rst;
    logic             sw_req;
    logic             sw_ack;
    logic             busy;
    logic [N_DOM-1:0] dom_rst;
`ifdef RST_SEQ_EVENT_CNT_EN
    logic [7:0]       sw_rst_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    rst_release_sequencer #(
        .N_DOM       (N_DOM),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_req     (sw_req),
        .sw_ack     (sw_ack),
        .busy       (busy),
`ifdef RST_SEQ_EVENT_CNT_EN
        .sw_rst_cnt (sw_rst_cnt),
`endif
        .dom_rst    (dom_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {dom_rst, busy, sw_ack} after edge k, where edge 'base' enters HOLD.
    function automatic logic [W-1:0] model(input int k, input int base, input bit sw);
        logic [N_DOM-1:0] d;
        logic [N_DOM-1:0] dp;
        for (int i = 0; i < N_DOM; i++) begin
            d[i]  = (k < base + HOLD_CYCLES + GAP_CYCLES * i);
            dp[i] = (k - 1 < base + HOLD_CYCLES + GAP_CYCLES * i);
        end
        return {d, |dp, sw && (k == base + HOLD_CYCLES + GAP_CYCLES * (N_DOM - 1))};
    endfunction

    task automatic push_seq(input int k0, input int n, input int base, input bit sw);
        for (int k = k0; k < k0 + n; k++) begin
            exp_q.push_back(model(k, base, sw));
        end
    endtask

    task automatic check_cycles(input int n, input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            obs = {dom_rst, busy, sw_ack};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL %s cycle %0d: observed %b, expected queue empty", tag, c, obs);
            end else begin
                exp = exp_q.pop_front();
                assert (obs === exp) else begin
                    n_fail++;
                    $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
                end
            end
        end
    endtask

    task automatic check_async_reset(input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        exp = {{N_DOM{1'b1}}, 1'b1, 1'b0};
        obs = {dom_rst, busy, sw_ack};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_rst_s(input logic expv, input string tag);
        n_checks++;
        assert (dut.rst_s === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, dut.rst_s, expv);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        sw_req   = 1'b0;

        // Reset must reach the outputs before any clock edge.
        #2 rst = 1'b1;
        #1 check_async_reset("por_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Power-on release schedule.
        push_seq(1, 40, POR_BASE, 1'b0);
        check_cycles(SYNC_STAGES - 1, "por");
        check_rst_s(1'b1, "rst_s_before_last_edge");
        check_cycles(1, "por");
        check_rst_s(1'b0, "rst_s_at_last_edge");
        check_cycles(40 - SYNC_STAGES, "por");

        // Software reset with sw_req held high well past sw_ack.
        sw_req = 1'b1;
        push_seq(1, 90, 1, 1'b1);
        check_cycles(90, "sw_held");

        // One low sample re-arms; the next high starts a new sequence.
        sw_req = 1'b0;
        exp_q.push_back('0);
        check_cycles(1, "sw_drop");
        sw_req = 1'b1;
        push_seq(1, 33, 1, 1'b1);
        check_cycles(33, "sw_rearm");

        // Another software sequence, interrupted by rst once dom_rst[1] is released.
        sw_req = 1'b0;
        exp_q.push_back('0);
        check_cycles(1, "sw_drop2");
        sw_req = 1'b1;
        push_seq(1, 22, 1, 1'b1);
        check_cycles(22, "sw_mid_rel");
        sw_req = 1'b0;
        #2 rst = 1'b1;
        #1 check_async_reset("mid_rel_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full re-run with no sw_ack; a request pulsed during HOLD is ignored.
        push_seq(1, 50, POR_BASE, 1'b0);
        check_cycles(8, "rerun");
        sw_req = 1'b1;
        check_cycles(4, "rerun_hold_req");
        sw_req = 1'b0;
        check_cycles(38, "rerun");

`ifdef RST_SEQ_EVENT_CNT_EN
        n_checks++;
        assert (sw_rst_cnt === 8'd0) else begin
            n_fail++;
            $error("FAIL cnt_after_rst: observed %0d expected 0", sw_rst_cnt);
        end
        for (int s = 0; s < 257; s++) begin
            bit got_ack;
            got_ack = 1'b0;
            sw_req  = 1'b1;
            for (int c = 0; c < 64 && !got_ack; c++) begin
                @(posedge clk);
                #1;
                got_ack = sw_ack;
            end
            n_checks++;
            assert (got_ack) else begin
                n_fail++;
                $error("FAIL cnt_seq_ack %0d: observed no sw_ack expected sw_ack within 64 cycles", s);
            end
            sw_req = 1'b0;
            @(posedge clk);
            #1;
        end
        n_checks++;
        assert (sw_rst_cnt === 8'd255) else begin
            n_fail++;
            $error("FAIL cnt_saturate: observed %0d expected 255", sw_rst_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        assert (sw_rst_cnt === 8'd0) else begin
            n_fail++;
            $error("FAIL cnt_clear: observed %0d expected 0", sw_rst_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
`endif

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
